router_output_scheduler: RTL and testbench

Per-output-port burst scheduler that shares the router's 3 output ports among its 17 input FIFOs. Each cycle it inspects every FIFO's empty flag and head-word destination. For each output port it grants one input at a time with round-robin fairness and holds the grant for a bounded burst. It drives the FIFO pop strobes and the output-port mux selects that the router datapath consumes.

---
 rtl/router_pkg.sv | 19 +
 rtl/rr_port_arbiter.sv | 84 ++++++++
 rtl/router_output_scheduler.sv | 59 +++++
 tb/tb_router_output_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, port FSM state and index helper for the output scheduler
package router_pkg;
    localparam int N_IN      = 17;
    localparam int N_OUT     = 3;
    localparam int SEL_W     = 5;
    localparam int DEST_W    = 2;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } port_state_e;

    // Next input index, wrapping N_IN-1 back to 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(N_IN - 1)) ? '0 : v + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - round-robin burst arbiter for one output port
module rr_port_arbiter
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [N_IN-1:0]  pop_o
);
    port_state_e      state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             found;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] cand;
    logic             owner_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // First requester at or after ptr, scanning once around the ring.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = ptr_q;
        for (int k = 0; k < N_IN; k++) begin
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    assign owner_req = req_i[owner_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        valid_o = 1'b0;
        sel_o   = '0;
        pop_o   = '0;
        case (state_q)
            ARB: begin
                if (found) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                sel_o   = owner_q;
                valid_o = owner_req;
                if (owner_req && ready_i) begin
                    pop_o[owner_q] = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                end
                // Owner lost its request, or this transfer completes the burst.
                if (!owner_req || (ready_i && cnt_q == CNT_W'(MAX_BURST - 1))) begin
                    state_d = ARB;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = ARB;
        endcase
    end
endmodule

// File: rtl/router_output_scheduler.sv
// rtl/router_output_scheduler.sv - shares N_OUT output ports among N_IN input FIFOs with burst grants and illegal-dest drop
module router_output_scheduler
    import router_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         fifo_empty,
    input  logic [N_IN*DEST_W-1:0]  fifo_dest,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_IN-1:0]         fifo_pop,
    output logic [N_OUT*SEL_W-1:0]  out_sel,
    output logic [N_OUT-1:0]        out_valid,
    output logic                    drop_pulse
);
    logic [N_OUT-1:0][N_IN-1:0] req;
    logic [N_OUT-1:0][N_IN-1:0] port_pop;
    logic [N_IN-1:0]            illegal;
    logic [N_IN-1:0]            drop_vec;

    always_comb begin
        req     = '0;
        illegal = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!fifo_empty[i]) begin
                if (fifo_dest[i*DEST_W +: DEST_W] >= DEST_W'(N_OUT)) begin
                    illegal[i] = 1'b1;
                end
                for (int p = 0; p < N_OUT; p++) begin
                    if (fifo_dest[i*DEST_W +: DEST_W] == DEST_W'(p)) begin
                        req[p][i] = 1'b1;
                    end
                end
            end
        end
    end

    // Isolate the lowest illegal index; suppressed while reset is held.
    assign drop_vec   = reset ? (illegal & (~illegal + N_IN'(1))) : '0;
    assign drop_pulse = |drop_vec;

    for (genvar p = 0; p < N_OUT; p++) begin : g_port
        rr_port_arbiter u_arb (
            .clk     (clk),
            .rst_n   (reset),
            .req_i   (req[p]),
            .ready_i (out_ready[p]),
            .valid_o (out_valid[p]),
            .sel_o   (out_sel[p*SEL_W +: SEL_W]),
            .pop_o   (port_pop[p])
        );
    end

    always_comb begin
        fifo_pop = drop_vec;
        for (int p = 0; p < N_OUT; p++) begin
            fifo_pop = fifo_pop | port_pop[p];
        end
    end
endmodule

// File: tb/tb_router_output_scheduler.sv
// tb/tb_router_output_scheduler.sv - self-checking bench for router_output_scheduler
module tb_router_output_scheduler;
    import router_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_IN-1:0]        fifo_empty;
    logic [N_IN*DEST_W-1:0] fifo_dest;
    logic [N_OUT-1:0]       out_ready;
    logic [N_IN-1:0]        fifo_pop;
    logic [N_OUT*SEL_W-1:0] out_sel;
    logic [N_OUT-1:0]       out_valid;
    logic                   drop_pulse;

    always #5 clk = ~clk;

    router_output_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dest  (fifo_dest),
        .out_ready  (out_ready),
        .fifo_pop   (fifo_pop),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .drop_pulse (drop_pulse)
    );

    int checks = 0;
    int errors = 0;

    int qd[N_IN][32];
    int qn[N_IN];
    logic [N_OUT-1:0] ready_v;

    bit m_gnt[N_OUT];
    int m_ptr[N_OUT];
    int m_own[N_OUT];
    int m_cnt[N_OUT];
    bit n_gnt[N_OUT];
    int n_ptr[N_OUT];
    int n_own[N_OUT];
    int n_cnt[N_OUT];
    logic [N_IN-1:0]  e_pop;
    logic [N_OUT-1:0] e_valid;
    logic             e_drop;
    int               e_sel[N_OUT];

    int               nrec;
    logic [N_OUT-1:0] r_valid[512];
    int               r_sel[512][N_OUT];
    logic [N_IN-1:0]  r_pop[512];
    logic             r_drop[512];

    typedef struct {
        logic [N_IN-1:0]        empty;
        logic [N_IN*DEST_W-1:0] dest;
        logic                   drop;
        logic [N_IN-1:0]        pop;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            if (qn[i] < 32) begin
                qd[i][qn[i]] = d;
                qn[i]++;
            end
        end
    endtask

    function automatic bit rq(input int i, input int p);
        return qn[i] > 0 && qd[i][0] == p;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N_IN; i++) begin
            fifo_empty[i] = (qn[i] == 0);
            fifo_dest[i*DEST_W +: DEST_W] = (qn[i] > 0) ? DEST_W'(qd[i][0]) : '0;
        end
        out_ready = ready_v;
    endtask

    task automatic model_reset();
        for (int p = 0; p < N_OUT; p++) begin
            m_gnt[p] = 0; m_ptr[p] = 0; m_own[p] = 0; m_cnt[p] = 0;
        end
    endtask

    task automatic model_eval();
        e_pop = '0; e_valid = '0; e_drop = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (qn[i] > 0 && qd[i][0] >= N_OUT && !e_drop) begin
                e_drop   = 1'b1;
                e_pop[i] = 1'b1;
            end
        end
        for (int p = 0; p < N_OUT; p++) begin
            bit found;
            n_gnt[p] = m_gnt[p]; n_ptr[p] = m_ptr[p]; n_own[p] = m_own[p]; n_cnt[p] = m_cnt[p];
            e_sel[p] = 0;
            found = 0;
            if (!m_gnt[p]) begin
                for (int k = 0; k < N_IN; k++) begin
                    int w;
                    w = (m_ptr[p] + k) % N_IN;
                    if (!found && rq(w, p)) begin
                        found = 1; n_gnt[p] = 1; n_own[p] = w; n_cnt[p] = 0;
                    end
                end
            end else begin
                e_sel[p]   = m_own[p];
                e_valid[p] = rq(m_own[p], p);
                if (e_valid[p] && ready_v[p]) begin
                    e_pop[m_own[p]] = 1'b1;
                    n_cnt[p] = m_cnt[p] + 1;
                end
                if (!e_valid[p] || n_cnt[p] == MAX_BURST) begin
                    n_gnt[p] = 0;
                    n_ptr[p] = (m_own[p] + 1) % N_IN;
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int p = 0; p < N_OUT; p++) begin
            m_gnt[p] = n_gnt[p]; m_ptr[p] = n_ptr[p]; m_own[p] = n_own[p]; m_cnt[p] = n_cnt[p];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (e_pop[i] && qn[i] > 0) begin
                for (int k = 1; k < qn[i]; k++) qd[i][k-1] = qd[i][k];
                qn[i]--;
            end
        end
    endtask

    task automatic tick();
        apply_inputs();
        @(negedge clk);
        model_eval();
        chk("pop", 64'(fifo_pop), 64'(e_pop));
        chk("valid", 64'(out_valid), 64'(e_valid));
        chk("drop", 64'(drop_pulse), 64'(e_drop));
        for (int p = 0; p < N_OUT; p++) begin
            if (m_gnt[p]) chk("sel", 64'(out_sel[p*SEL_W +: SEL_W]), 64'(e_sel[p]));
        end
        if (nrec < 512) begin
            r_valid[nrec] = out_valid;
            for (int p = 0; p < N_OUT; p++) r_sel[nrec][p] = int'(out_sel[p*SEL_W +: SEL_W]);
            r_pop[nrec]  = fifo_pop;
            r_drop[nrec] = drop_pulse;
            nrec++;
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < N_IN; i++) qn[i] = 0;
        model_reset();
        ready_v = '1;
        apply_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nrec  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int cnt;
        int nr;
        int ord[8];
        int len[8];
        int exp_ord[6];
        logic [15:0] pat;
        logic [15:0] pat2;
        bit prev;

        // Reset state, with an illegal word and a legal request present
        reset = 1'b0;
        ready_v = '1;
        for (int i = 0; i < N_IN; i++) qn[i] = 0;
        model_reset();
        nrec = 0;
        push(7, 3, 1);
        push(5, 1, 2);
        apply_inputs();
        #2;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_pop", 64'(fifo_pop), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));
        chk("rst_drop", 64'(drop_pulse), 64'(0));

        // Drop-priority table, evaluated in the first cycle after reset
        vecs[0] = '{17'h1FFFF, 34'h3FFFFFFFF, 1'b0, 17'h00000};
        vecs[1] = '{17'h1FF7F, 34'h3FFFFFFFF, 1'b1, 17'h00080};
        vecs[2] = '{17'h1EF7F, 34'h3FFFFFFFF, 1'b1, 17'h00080};
        vecs[3] = '{17'h00000, 34'h000000000, 1'b0, 17'h00000};
        vecs[4] = '{17'h0FFFF, 34'h3FFFFFFFF, 1'b1, 17'h10000};
        vecs[5] = '{17'h00000, 34'h155555575, 1'b1, 17'h00004};
        vecs[6] = '{17'h00000, 34'h2AAAAAAAA, 1'b0, 17'h00000};
        vecs[7] = '{17'h00001, 34'h3FFFFFFFF, 1'b1, 17'h00002};
        for (int v = 0; v < 8; v++) begin
            fifo_empty = vecs[v].empty;
            fifo_dest  = vecs[v].dest;
            out_ready  = '1;
            @(posedge clk);
            #1;
            reset = 1'b1;
            #2;
            chk($sformatf("tbl%0d_drop", v), 64'(drop_pulse), 64'(vecs[v].drop));
            chk($sformatf("tbl%0d_pop", v), 64'(fifo_pop), 64'(vecs[v].pop));
            chk($sformatf("tbl%0d_valid", v), 64'(out_valid), 64'(0));
            reset = 1'b0;
            #1;
        end

        // Single burst: 4 words, one bubble, 2 words
        do_reset();
        push(5, 1, 6);
        repeat (10) tick();
        pat = '0; cnt = 0;
        for (int t = 0; t < 10; t++) begin
            pat[t] = r_valid[t][1];
            if (r_valid[t][1] && r_sel[t][1] != 5) cnt++;
        end
        chk("burst_pattern", 64'(pat), 64'h0DE);
        chk("burst_sel", 64'(cnt), 64'(0));
        cnt = 0;
        for (int t = 0; t < 10; t++) if (r_pop[t][5]) cnt++;
        chk("burst_pops", 64'(cnt), 64'(6));

        // Fairness wrap from ptr 9
        do_reset();
        push(8, 0, 1);
        repeat (3) tick();
        push(0, 0, 8); push(16, 0, 8); push(8, 0, 8);
        nrec = 0;
        repeat (30) tick();
        exp_ord = '{16, 0, 8, 16, 0, 8};
        nr = 0; prev = 0;
        for (int t = 0; t < nrec; t++) begin
            if (r_valid[t][0]) begin
                if (!prev) begin
                    if (nr < 8) begin ord[nr] = r_sel[t][0]; len[nr] = 0; end
                    nr++;
                end
                if (nr >= 1 && nr <= 8) len[nr-1]++;
            end
            prev = r_valid[t][0];
        end
        chk("fair_grants", 64'(nr), 64'(6));
        for (int g = 0; g < 6 && g < nr; g++) begin
            chk($sformatf("fair_owner%0d", g), 64'(ord[g]), 64'(exp_ord[g]));
            chk($sformatf("fair_len%0d", g), 64'(len[g]), 64'(MAX_BURST));
        end

        // Backpressure mid-burst
        do_reset();
        push(3, 2, 6);
        repeat (3) tick();
        ready_v[2] = 1'b0;
        repeat (5) tick();
        ready_v = '1;
        repeat (3) tick();
        cnt = 0;
        for (int t = 3; t < 8; t++) if (!r_valid[t][2] || r_pop[t][3]) cnt++;
        chk("stall_hold", 64'(cnt), 64'(0));
        pat = '0;
        for (int t = 8; t < 11; t++) pat[t-8] = r_valid[t][2];
        chk("stall_resume", 64'(pat), 64'h3);
        cnt = 0;
        for (int t = 0; t < 11; t++) if (r_pop[t][3]) cnt++;
        chk("stall_words", 64'(cnt), 64'(MAX_BURST));

        // Parallel ports with an illegal destination
        do_reset();
        push(1, 0, 3); push(2, 1, 3); push(4, 2, 3); push(7, 3, 1);
        repeat (5) tick();
        chk("par_drop0", 64'(r_drop[0]), 64'(1));
        chk("par_pop0", 64'(r_pop[0]), 64'h80);
        chk("par_valid1", 64'(r_valid[1]), 64'h7);
        chk("par_drop1", 64'(r_drop[1]), 64'(0));
        cnt = 0;
        for (int t = 0; t < 5; t++)
            for (int p = 0; p < N_OUT; p++)
                if (r_valid[t][p] && r_sel[t][p] == 7) cnt++;
        chk("par_no_sel7", 64'(cnt), 64'(0));

        // Early release on destination change
        do_reset();
        push(9, 0, 2); push(9, 2, 1);
        repeat (6) tick();
        pat = '0; pat2 = '0;
        for (int t = 0; t < 6; t++) begin
            pat[t]  = r_valid[t][0];
            pat2[t] = r_valid[t][2];
        end
        chk("early_p0", 64'(pat), 64'h06);
        chk("early_p2", 64'(pat2), 64'h10);
        chk("early_sel2", 64'(r_sel[4][2]), 64'(9));

        // Reset mid-burst
        do_reset();
        push(2, 1, 1);
        repeat (3) tick();
        push(1, 1, 8); push(5, 1, 8);
        repeat (3) tick();
        chk("mid_sel_before", 64'(r_sel[4][1]), 64'(5));
        chk("mid_words_before", 64'({r_pop[4][5], r_pop[5][5]}), 64'h3);
        reset = 1'b0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'(0));
        chk("mid_pop", 64'(fifo_pop), 64'(0));
        chk("mid_sel", 64'(out_sel), 64'(0));
        chk("mid_drop", 64'(drop_pulse), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        nrec = 0;
        repeat (3) tick();
        chk("mid_restart_valid", 64'(r_valid[1][1]), 64'(1));
        chk("mid_restart_sel", 64'(r_sel[1][1]), 64'(1));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N_OUT; p++) ready_v[p] = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int i;
                int d;
                i = $urandom_range(0, N_IN - 1);
                d = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, N_OUT - 1);
                push(i, d, $urandom_range(1, 6));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
